cic_decim_pow2: RTL and testbench

Parametrised N-stage CIC decimator with runtime power-of-two decimation (R = 2^k, 1 ≤ R ≤ 2^RMAX_LOG2) and an input valid qualifier. The output is gain-normalised, rounded and saturated back to DATA_W. It sits in the DFE receive chain ahead of the compensation FIR and supersedes the fixed 3-stage CIC. It adds:

- configurable order;
- sample-valid gating;
- decimated-rate comb evaluation;
- clean reconfiguration of the decimation factor.

---
 rtl/cic_decim_pow2.sv | 124 ++++++++++++
 tb/tb_cic_decim_pow2.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_pow2.sv
// N-stage CIC decimator with runtime power-of-two rate, valid gating and
// gain-normalised, rounded, saturated output.
module cic_decim_pow2 #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ORDER     = 3,
  parameter int unsigned RMAX_LOG2 = 4,
  parameter int unsigned ACC_W     = DATA_W + ORDER * RMAX_LOG2,
  parameter int unsigned K_W       = $clog2(RMAX_LOG2 + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [K_W-1:0]    dec_log2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);

  localparam int unsigned PH_W = (RMAX_LOG2 > 0) ? RMAX_LOG2 : 1;
  localparam int unsigned S_W  = (ORDER * RMAX_LOG2 > 0) ? $clog2(ORDER * RMAX_LOG2 + 1) : 1;

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic [K_W-1:0]    r_k_act;
  logic [PH_W-1:0]   r_ph;
  logic [ACC_W-1:0]  r_integ [ORDER];
  logic [ACC_W-1:0]  r_dly   [ORDER];
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sat;

  logic [K_W-1:0]           w_k_req;
  logic                     w_reconfig;
  logic                     w_accept;
  logic [PH_W-1:0]          w_ph_last;
  logic                     w_close;
  logic [ACC_W-1:0]         w_in_ext;
  logic [ACC_W-1:0]         w_integ_nxt [ORDER];
  logic [ACC_W-1:0]         w_comb      [ORDER+1];
  logic [S_W-1:0]           w_s;
  logic signed [ACC_W:0]    w_round;
  logic signed [ACC_W:0]    w_sum;
  logic signed [ACC_W:0]    w_shift;
  logic [DATA_W-1:0]        w_y;
  logic                     w_sat;

  // Requested rate clamp and reconfiguration detect; a mismatch drops the sample
  assign w_k_req    = (dec_log2 > K_W'(RMAX_LOG2)) ? K_W'(RMAX_LOG2) : dec_log2;
  assign w_reconfig = (w_k_req != r_k_act);
  assign w_accept   = in_valid && !w_reconfig;
  assign w_ph_last  = PH_W'((32'd1 << r_k_act) - 32'd1);
  assign w_close    = w_accept && (r_ph == w_ph_last);
  assign w_in_ext   = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};

  // Integrator cascade (new values feed forward) and decimated-rate combs
  always_comb begin
    w_integ_nxt[0] = r_integ[0] + w_in_ext;
    for (int i = 1; i < ORDER; i++) begin
      w_integ_nxt[i] = r_integ[i] + w_integ_nxt[i-1];
    end
    w_comb[0] = w_integ_nxt[ORDER-1];
    for (int i = 0; i < ORDER; i++) begin
      w_comb[i+1] = w_comb[i] - r_dly[i];
    end
  end

  // Gain removal by R^N = 2^(N*k), round half up, then clip to DATA_W
  always_comb begin
    w_s     = S_W'(r_k_act) * S_W'(ORDER);
    w_round = '0;
    if (w_s != '0) begin
      w_round = (ACC_W + 1)'(1) << (w_s - S_W'(1));
    end
    w_sum   = {w_comb[ORDER][ACC_W-1], w_comb[ORDER]} + w_round;
    w_shift = w_sum >>> w_s;
    w_sat   = 1'b0;
    w_y     = w_shift[DATA_W-1:0];
    if (w_shift > SAT_MAX) begin
      w_y   = SAT_MAX[DATA_W-1:0];
      w_sat = 1'b1;
    end else if (w_shift < SAT_MIN) begin
      w_y   = SAT_MIN[DATA_W-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_reconfig) begin
      r_k_act     <= w_k_req;
      r_ph        <= '0;
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
      for (int i = 0; i < ORDER; i++) begin
        r_integ[i] <= '0;
        r_dly[i]   <= '0;
      end
      if (rst) begin
        r_out_data <= '0;
      end
    end else begin
      r_out_valid <= w_close;
      r_out_sat   <= w_close && w_sat;
      if (w_accept) begin
        r_ph <= w_close ? '0 : r_ph + PH_W'(1);
        for (int i = 0; i < ORDER; i++) begin
          r_integ[i] <= w_integ_nxt[i];
        end
      end
      if (w_close) begin
        r_out_data <= w_y;
        for (int i = 0; i < ORDER; i++) begin
          r_dly[i] <= w_comb[i];
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_cic_decim_pow2.sv
// Self-checking bench for cic_decim_pow2: randomized stimulus against a
// convolution-based reference (impulse response = boxcar^N, gain R^N).
module tb_cic_decim_pow2;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ORDER     = 3;
  localparam int unsigned RMAX_LOG2 = 4;
  localparam int unsigned K_W       = $clog2(RMAX_LOG2 + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [K_W-1:0]    dec_log2;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: active k, accepted samples since last clear, expected outputs
  int                m_k;
  longint            m_x[$];
  bit                exp_v;
  bit                exp_sat;
  logic [DATA_W-1:0] exp_d;

  cic_decim_pow2 #(.DATA_W(DATA_W), .ORDER(ORDER), .RMAX_LOG2(RMAX_LOG2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .dec_log2(dec_log2), .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  function automatic int clampk(input int d);
    return (d > int'(RMAX_LOG2)) ? int'(RMAX_LOG2) : d;
  endfunction

  // Output = (x * h)[n] / R^N, h = (1 + z^-1 + ... + z^-(R-1))^N
  function automatic void model_eval(output logic [DATA_W-1:0] y, output bit sat);
    longint h[64];
    longint t[64];
    int r, len, n, s;
    longint full, q, hi, lo;
    r = 1 << m_k;
    len = 1;
    foreach (h[i]) h[i] = 0;
    h[0] = 1;
    for (int st = 0; st < int'(ORDER); st++) begin
      foreach (t[i]) t[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < r; j++) t[i+j] += h[i];
      len += r - 1;
      h = t;
    end
    n = m_x.size();
    full = 0;
    for (int j = 0; j < len && j < n; j++) full += m_x[n-1-j] * h[j];
    s = int'(ORDER) * m_k;
    q = (s > 0) ? ((full + (longint'(1) << (s - 1))) >>> s) : full;
    hi = (longint'(1) << (DATA_W - 1)) - 1;
    lo = -hi - 1;
    sat = 1'b0;
    if (q > hi) begin q = hi; sat = 1'b1; end
    else if (q < lo) begin q = lo; sat = 1'b1; end
    y = DATA_W'(q);
  endfunction

  task automatic do_reset(input int dec);
    rst = 1'b1; in_valid = 1'b0; in_data = '0; dec_log2 = K_W'(dec);
    @(posedge clk); #1;
    rst = 1'b0;
    m_k = clampk(dec); m_x.delete();
    exp_v = 1'b0; exp_d = '0; exp_sat = 1'b0;
  endtask

  task automatic step(input bit v, input int d, input int dec);
    int req;
    req = clampk(dec);
    in_valid = v; in_data = DATA_W'(d); dec_log2 = K_W'(dec);
    exp_v = 1'b0; exp_sat = 1'b0;
    if (req != m_k) begin
      m_k = req;
      m_x.delete();
    end else if (v) begin
      m_x.push_back(longint'(d));
      if (m_x.size() % (1 << m_k) == 0) begin
        exp_v = 1'b1;
        model_eval(exp_d, exp_sat);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got v=%b d=%0d sat=%b, expected 0/0/0", out_valid, $signed(out_data), out_sat);
    end
  endtask

  task automatic test_impulse(input int amp, input int w0, input int w1, input int w2);
    int p[$];
    int want[4];
    want = '{w0, w1, w2, 0};
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i == 0) ? amp : 0, 2);
      n_tests++;
      if (out_valid !== exp_v || out_data !== exp_d || out_sat !== exp_sat) begin
        n_fail++;
        $display("FAIL impulse(%0d) step %0d: got v=%b d=%0d sat=%b, expected v=%b d=%0d sat=%b",
                 amp, i, out_valid, $signed(out_data), out_sat, exp_v, $signed(exp_d), exp_sat);
      end
      if (out_valid === 1'b1) p.push_back(int'($signed(out_data)));
    end
    n_tests++;
    if (p.size() != 4) begin
      n_fail++;
      $display("FAIL impulse(%0d) pulse count: got %0d, expected 4", amp, p.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (p[i] != want[i]) begin
          n_fail++;
          $display("FAIL impulse(%0d) pulse %0d: got %0d, expected %0d", amp, i, p[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_passthrough();
    int vals[4];
    int d;
    vals = '{5, -7, 32767, -32768};
    do_reset(2);
    step(1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vals[i], 0);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(vals[i]) || out_sat !== 1'b0) begin
        n_fail++;
        $display("FAIL passthrough %0d: got v=%b d=%0d sat=%b, expected v=1 d=%0d sat=0",
                 i, out_valid, $signed(out_data), out_sat, vals[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      d = int'($urandom_range(65535)) - 32768;
      step(1'b1, d, 0);
      n_tests++;
      if (out_valid !== exp_v || out_data !== exp_d || out_sat !== exp_sat) begin
        n_fail++;
        $display("FAIL passthrough rand %0d: got v=%b d=%0d, expected v=%b d=%0d",
                 i, out_valid, $signed(out_data), exp_v, $signed(exp_d));
      end
    end
  endtask

  task automatic test_dc_fullscale();
    int lvl[2];
    lvl = '{32767, -32768};
    do_reset(4);
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 80; i++) begin
        step(1'b1, lvl[l], 4);
        n_tests++;
        if (out_valid !== exp_v || out_data !== exp_d || out_sat !== exp_sat) begin
          n_fail++;
          $display("FAIL dc(%0d) step %0d: got v=%b d=%0d sat=%b, expected v=%b d=%0d sat=%b",
                   lvl[l], i, out_valid, $signed(out_data), out_sat, exp_v, $signed(exp_d), exp_sat);
        end
      end
      n_tests++;
      if (out_data !== DATA_W'(lvl[l]) || out_sat !== 1'b0) begin
        n_fail++;
        $display("FAIL dc settle: got d=%0d sat=%b, expected d=%0d sat=0", $signed(out_data), out_sat, lvl[l]);
      end
    end
  endtask

  task automatic test_valid_gaps();
    int ref_p[$];
    int gap_p[$];
    int acc;
    bit v;
    do_reset(2);
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1000, 2);
      if (out_valid === 1'b1) ref_p.push_back(int'($signed(out_data)));
    end
    do_reset(2);
    acc = 0;
    for (int c = 0; c < 400 && acc < 24; c++) begin
      v = $urandom_range(1);
      step(v, v ? 1000 : int'($urandom_range(255)), 2);
      if (v) acc++;
      n_tests++;
      if (out_valid !== exp_v || out_data !== exp_d || out_sat !== exp_sat) begin
        n_fail++;
        $display("FAIL gaps cycle %0d: got v=%b d=%0d, expected v=%b d=%0d",
                 c, out_valid, $signed(out_data), exp_v, $signed(exp_d));
      end
      if (out_valid === 1'b1) gap_p.push_back(int'($signed(out_data)));
    end
    n_tests++;
    if (acc != 24 || gap_p.size() != 6 || ref_p.size() != 6) begin
      n_fail++;
      $display("FAIL gaps pulses: accepted %0d gap pulses %0d ref pulses %0d, expected 24/6/6",
               acc, gap_p.size(), ref_p.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (gap_p[i] != ref_p[i]) begin
          n_fail++;
          $display("FAIL gaps pulse %0d: got %0d, expected %0d", i, gap_p[i], ref_p[i]);
        end
      end
      n_tests++;
      if (gap_p[5] != 1000) begin
        n_fail++;
        $display("FAIL gaps settle: got %0d, expected 1000", gap_p[5]);
      end
    end
  endtask

  task automatic test_reconfig();
    int first;
    do_reset(2);
    for (int i = 0; i < 6; i++) step(1'b1, 1000, 2);
    step(1'b1, 1000, 3);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== exp_d) begin
      n_fail++;
      $display("FAIL reconfig drop: got v=%b d=%0d, expected v=0 d=%0d", out_valid, $signed(out_data), $signed(exp_d));
    end
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1000, 3);
      n_tests++;
      if (out_valid !== exp_v || out_data !== exp_d || out_sat !== exp_sat) begin
        n_fail++;
        $display("FAIL reconfig sample %0d: got v=%b d=%0d, expected v=%b d=%0d",
                 i, out_valid, $signed(out_data), exp_v, $signed(exp_d));
      end
      if (out_valid === 1'b1 && first < 0) first = i;
    end
    n_tests++;
    if (first != 8 || out_data !== DATA_W'(1000)) begin
      n_fail++;
      $display("FAIL reconfig timing: first pulse at %0d final %0d, expected 8 and 1000", first, $signed(out_data));
    end
  endtask

  task automatic test_reset_midframe();
    do_reset(2);
    for (int i = 0; i < 6; i++) step(1'b1, 1000, 2);
    do_reset(2);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe reset: got v=%b d=%0d sat=%b, expected 0/0/0", out_valid, $signed(out_data), out_sat);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1000, 2);
      n_tests++;
      if (out_valid !== (i == 4) || out_data !== exp_d) begin
        n_fail++;
        $display("FAIL midframe phase %0d: got v=%b d=%0d, expected v=%b d=%0d",
                 i, out_valid, $signed(out_data), (i == 4), $signed(exp_d));
      end
    end
  endtask

  task automatic test_random();
    int dec;
    dec = 1;
    do_reset(dec);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(79) == 0) dec = int'($urandom_range(7));
      step($urandom_range(9) < 7, int'($urandom_range(65535)) - 32768, dec);
      n_tests++;
      if (out_valid !== exp_v || out_data !== exp_d || out_sat !== exp_sat) begin
        n_fail++;
        $display("FAIL random cycle %0d dec %0d: got v=%b d=%0d sat=%b, expected v=%b d=%0d sat=%b",
                 c, dec, out_valid, $signed(out_data), out_sat, exp_v, $signed(exp_d), exp_sat);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; dec_log2 = '0;
    test_reset();
    test_impulse(6400, 1000, 600, 0);
    test_impulse(-6400, -1000, -600, 0);
    test_impulse(1, 0, 0, 0);
    test_passthrough();
    test_dc_fullscale();
    test_valid_gaps();
    test_reconfig();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
